// File: rtl/mac_seq_ctrl.sv
// Sequencer feeding the first mac_col of a chain: loads K vectors, then executes Q vectors,
// then waits for the last column's fifo_wr pulses (with a drain timeout).

module mac_seq_lane #(
  parameter int bw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic [bw-1:0] d,
  output logic [bw-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (ld) q <= d;
  end
endmodule

module mac_seq_ctrl #(
  parameter int bw  = 8,
  parameter int pr  = 8,
  parameter int aw  = 6,
  parameter int cw  = 4,
  parameter int gap = 2,    // must be >= 1
  parameter int tmo = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [cw-1:0]    num_k,
  input  logic [cw-1:0]    num_q,
  input  logic [aw-1:0]    k_base,
  input  logic [aw-1:0]    q_base,
  output logic             mem_rd,
  output logic [aw-1:0]    mem_addr,
  input  logic [bw*pr-1:0] mem_rdata,
  output logic [bw*pr-1:0] q_in,
  output logic [1:0]       i_inst,
  input  logic             fifo_wr_in,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int GW = (gap > 1) ? $clog2(gap) : 1;
  localparam int TW = $clog2(tmo + 1);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, EXEC, DRAIN} state_t;

  state_t        state;
  logic [cw-1:0] nk, nq, idx, fcnt;
  logic [aw-1:0] qb;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      nk       <= '0;
      nq       <= '0;
      idx      <= '0;
      fcnt     <= '0;
      qb       <= '0;
      gcnt     <= '0;
      tcnt     <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Completion pulses may arrive before DRAIN (short chains); count them all while active.
      if (state != IDLE && fifo_wr_in && fcnt != '1) fcnt <= fcnt + cw'(1);
      case (state)
        IDLE: if (start) begin
          nk   <= num_k;
          nq   <= num_q;
          qb   <= q_base;
          busy <= 1'b1;
          fcnt <= '0;
          idx  <= '0;
          gcnt <= '0;
          if (num_k != '0) begin
            state    <= LOAD;
            mem_rd   <= 1'b1;
            mem_addr <= k_base;
          end else begin
            state <= GAP;
          end
        end
        LOAD: if (idx == nk - cw'(1)) begin
          state  <= GAP;
          mem_rd <= 1'b0;
          gcnt   <= '0;
        end else begin
          idx      <= idx + cw'(1);
          mem_addr <= mem_addr + aw'(1);
        end
        GAP: if (gcnt == GW'(gap - 1)) begin
          idx  <= '0;
          tcnt <= '0;
          if (nq != '0) begin
            state    <= EXEC;
            mem_rd   <= 1'b1;
            mem_addr <= qb;
          end else begin
            state <= DRAIN;
          end
        end else begin
          gcnt <= gcnt + GW'(1);
        end
        EXEC: if (idx == nq - cw'(1)) begin
          state  <= DRAIN;
          mem_rd <= 1'b0;
          tcnt   <= '0;
        end else begin
          idx      <= idx + cw'(1);
          mem_addr <= mem_addr + aw'(1);
        end
        DRAIN: if (fcnt >= nq) begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else if (tcnt == TW'(tmo - 1)) begin
          state <= IDLE;
          err   <= 1'b1;
          busy  <= 1'b0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Instruction goes out with the SRAM return cycle, one cycle ahead of its registered data word.
  always_ff @(posedge clk) begin
    if (reset)        i_inst <= 2'b00;
    else if (!mem_rd) i_inst <= 2'b00;
    else              i_inst <= (state == LOAD) ? 2'b01 : 2'b10;
  end

  genvar l;
  generate
    for (l = 0; l < pr; l++) begin : g_lane
      mac_seq_lane #(.bw(bw)) u_lane (
        .clk   (clk),
        .reset (reset),
        .ld    (i_inst != 2'b00),
        .d     (mem_rdata[l*bw +: bw]),
        .q     (q_in[l*bw +: bw])
      );
    end
  endgenerate
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized/directed bench for mac_seq_ctrl: per-cycle trace compared to a schedule model.

module tb_mac_seq_ctrl;
  localparam int BW = 8, PR = 8, AW = 6, CW = 4, GAP = 2, TMO = 255;
  localparam int DW = BW * PR;
  localparam int MAXC = 512;

  typedef struct packed {
    logic          busy, done, err, rd;
    logic [AW-1:0] addr;
    logic [1:0]    inst;
    logic [DW-1:0] q;
  } snap_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, fifo_wr_in = 1'b0;
  logic [CW-1:0] num_k = '0, num_q = '0;
  logic [AW-1:0] k_base = '0, q_base = '0;
  logic          mem_rd, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0, q_in;
  logic [1:0]    i_inst;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] q_hold;
  snap_t exp_tr [MAXC];
  snap_t obs_tr [MAXC];
  int n_chk = 0, n_fail = 0;

  mac_seq_ctrl #(.bw(BW), .pr(PR), .aw(AW), .cw(CW), .gap(GAP), .tmo(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_k(num_k), .num_q(num_q),
    .k_base(k_base), .q_base(q_base), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .q_in(q_in), .i_inst(i_inst), .fifo_wr_in(fifo_wr_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Builds the expected trace from the schedule rules, then drives and captures the DUT.
  task automatic run_seq(input int nk, input int nq, input int kb, input int qb,
                         input int npulse, input int poff, input int pstep,
                         input bit restart, output int len);
    bit qset [MAXC];
    logic [DW-1:0] qval [MAXC];
    bit pul [MAXC];
    int e, p, cnt, c0, endc, r, a;
    logic [DW-1:0] qh;
    for (int c = 0; c < MAXC; c++) begin
      exp_tr[c] = '0; qset[c] = 1'b0; qval[c] = '0; pul[c] = 1'b0;
    end
    for (int k = 0; k < nk + nq; k++) begin
      r = (k < nk) ? 1 + k : 1 + nk + GAP + (k - nk);
      a = (k < nk) ? (kb + k) % 64 : (qb + k - nk) % 64;
      exp_tr[r].rd = 1'b1;
      exp_tr[r].addr = AW'(a);
      exp_tr[r+1].inst = (k < nk) ? 2'b01 : 2'b10;
      qset[r+2] = 1'b1;
      qval[r+2] = mem[a];
    end
    e = 1 + nk + GAP + nq;
    for (int i = 0; i < npulse; i++) begin
      p = e + poff + i * pstep;
      if (p >= 1 && p < MAXC) pul[p] = 1'b1;
    end
    cnt = 0; p = -1;
    for (int c = 1; c < MAXC; c++) begin
      if (pul[c]) cnt++;
      if (nq > 0 && cnt == nq && p < 0) p = c;
    end
    if (nq == 0)     c0 = e;
    else if (p >= 0) c0 = (p + 1 > e) ? p + 1 : e;
    else             c0 = MAXC;
    if (c0 <= e + TMO - 1) begin endc = c0 + 1; exp_tr[endc].done = 1'b1; end
    else begin endc = e + TMO; exp_tr[endc].err = 1'b1; end
    len = endc + 3;
    qh = q_hold;
    for (int c = 0; c < len; c++) begin
      if (qset[c]) qh = qval[c];
      exp_tr[c].q = qh;
      exp_tr[c].busy = (c >= 1 && c < endc);
    end
    q_hold = qh;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      obs_tr[c].busy = busy; obs_tr[c].done = done; obs_tr[c].err = err;
      obs_tr[c].rd = mem_rd; obs_tr[c].addr = mem_rd ? mem_addr : '0;
      obs_tr[c].inst = i_inst; obs_tr[c].q = q_in;
      if (c == 0) begin
        num_k = CW'(nk); num_q = CW'(nq); k_base = AW'(kb); q_base = AW'(qb);
      end else if (c == 2 && restart) begin
        num_k = 4'd7; num_q = 4'd7; k_base = 6'd33; q_base = 6'd44;
      end
      start = (c == 0) || (restart && c == 2);
      fifo_wr_in = pul[c];
    end
    start = 1'b0;
    fifo_wr_in = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, err, mem_rd, i_inst, q_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b done=%b err=%b rd=%b inst=%b q=%h want all 0",
               busy, done, err, mem_rd, i_inst, q_in);
    end
    reset = 1'b0;
    q_hold = '0;
  endtask

  task automatic test_basic;
    int len, n01;
    run_seq(3, 3, 0, 8, 3, 1, 2, 1'b0, len);
    n01 = 0;
    for (int c = 0; c < len; c++) begin
      if (obs_tr[c].inst == 2'b01) n01++;
      n_chk++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_fail++;
        $display("FAIL basic cyc %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    n_chk++;
    if (n01 !== 3) begin n_fail++; $display("FAIL basic_load_cnt got %0d want 3", n01); end
  endtask

  task automatic test_no_load;
    int len;
    run_seq(0, 2, 5, 20, 2, -1, 3, 1'b0, len);
    for (int c = 0; c < len; c++) begin
      n_chk++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_fail++;
        $display("FAIL no_load cyc %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_timeout;
    int len, e;
    run_seq(2, 2, 10, 30, 1, 2, 1, 1'b0, len);
    e = 1 + 2 + GAP + 2;
    for (int c = 0; c < len; c++) begin
      n_chk++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_fail++;
        $display("FAIL timeout cyc %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    n_chk++;
    if (obs_tr[e + TMO].err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err_at_tmo got %b want 1", obs_tr[e + TMO].err);
    end
  endtask

  task automatic test_wrap;
    int len;
    run_seq(1, 3, 4, 62, 3, 0, 1, 1'b0, len);
    for (int c = 0; c < len; c++) begin
      n_chk++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_fail++;
        $display("FAIL wrap cyc %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_restart_ignored;
    int len;
    run_seq(3, 3, 0, 8, 3, 1, 2, 1'b1, len);
    for (int c = 0; c < len; c++) begin
      n_chk++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_fail++;
        $display("FAIL restart cyc %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_random;
    int len, nk, nq, np;
    for (int it = 0; it < 8; it++) begin
      nk = $urandom_range(0, 15);
      nq = $urandom_range(0, 15);
      np = $urandom_range(0, 3) == 0 ? (nq > 0 ? nq - 1 : 0) : nq;
      run_seq(nk, nq, $urandom_range(0, 63), $urandom_range(0, 63), np,
              $urandom_range(0, 6) - 2, $urandom_range(1, 3), $urandom_range(0, 1), len);
      for (int c = 0; c < len; c++) begin
        n_chk++;
        if (obs_tr[c] !== exp_tr[c]) begin
          n_fail++;
          $display("FAIL random it %0d cyc %0d got %h want %h", it, c, obs_tr[c], exp_tr[c]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 8) begin
        n_chk++;
        if ({busy, done, err, mem_rd, i_inst, q_in} !== '0) begin
          n_fail++;
          $display("FAIL mid_reset cyc %0d got busy=%b done=%b rd=%b inst=%b q=%h want all 0",
                   c, busy, done, mem_rd, i_inst, q_in);
        end
      end else if (c > 8) begin
        n_chk++;
        if ({busy, done, err, mem_rd, i_inst} !== '0) begin
          n_fail++;
          $display("FAIL mid_reset_idle cyc %0d got busy=%b done=%b err=%b rd=%b inst=%b want 0",
                   c, busy, done, err, mem_rd, i_inst);
        end
      end
      if (c == 0) begin num_k = 4'd3; num_q = 4'd5; k_base = 6'd0; q_base = 6'd8; end
      start = (c == 0);
      fifo_wr_in = (c == 7);
      reset = (c == 7 || c == 8);
    end
    start = 1'b0;
    fifo_wr_in = 1'b0;
    reset = 1'b0;
    q_hold = '0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    q_hold = '0;
    test_reset;
    test_basic;
    test_no_load;
    test_timeout;
    test_wrap;
    test_restart_ignored;
    test_random;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
